// File: rtl/seven_seg_scan_capture_if.sv
// Bundle between the 7-segment display bus monitor and its environment.
// The slave side is the capture block; the master side drives the bus and observes frames.
interface seven_seg_scan_capture_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic [6:0]            segments;
  logic [DIGITS-1:0]     anode_active;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     digit_valid;
  logic                  frame_valid;
  logic                  frame_done;
  logic                  err;

  modport master (
    output en, segments, anode_active,
    input  value, digit_valid, frame_valid, frame_done, err
  );

  modport slave (
    input  en, segments, anode_active,
    output value, digit_valid, frame_valid, frame_done, err
  );
endinterface

// File: rtl/seven_seg_scan_capture.sv
// Recovers BCD digits from a multiplexed active-low 7-segment bus: samples, debounces,
// decodes each digit position and publishes a complete frame once every position was seen.
module seven_seg_scan_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  seven_seg_scan_capture_if.slave  bus
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]     CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]     CNT_PRE = CW'(STABLE_CYCLES - 2);
  localparam logic [DIGITS-1:0] AN_ONE  = DIGITS'(1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  // Returns {valid, illegal, nibble} for an active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    logic [5:0] r;
    case (seg)
      7'b1000000: r = {2'b10, 4'd0};
      7'b1111001: r = {2'b10, 4'd1};
      7'b0100100: r = {2'b10, 4'd2};
      7'b0110000: r = {2'b10, 4'd3};
      7'b0011001: r = {2'b10, 4'd4};
      7'b0010010: r = {2'b10, 4'd5};
      7'b0000010: r = {2'b10, 4'd6};
      7'b1111000: r = {2'b10, 4'd7};
      7'b0000000: r = {2'b10, 4'd8};
      7'b0010000: r = {2'b10, 4'd9};
      7'b1111111: r = {2'b00, 4'hF};
      default:    r = {2'b01, 4'hE};
    endcase
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [6:0]            smp_seg_q;
  logic [DIGITS-1:0]     smp_an_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  acc_q, acc_d;
  logic [DIGITS-1:0]     seen_q, seen_d;
  logic                  err_q, err_d;
  logic [4*DIGITS-1:0]   shadow_nib_q;
  logic [DIGITS-1:0]     shadow_vld_q;
  logic [4*DIGITS-1:0]   value_q;
  logic [DIGITS-1:0]     digit_valid_q;
  logic                  frame_valid_q;

  logic                  same, accept, an_zero, an_onehot, capture, load;
  logic [5:0]            dec;

  assign same      = ({bus.anode_active, bus.segments} == {smp_an_q, smp_seg_q});
  assign dec       = seg_decode(smp_seg_q);
  assign accept    = acc_q & bus.en;
  assign an_zero   = (smp_an_q == '0);
  assign an_onehot = !an_zero && ((smp_an_q & (smp_an_q - AN_ONE)) == '0);
  assign capture   = accept & an_onehot;

  // acc_q marks the one cycle in which the counter first reaches saturation
  always_comb begin
    cnt_d = '0;
    acc_d = 1'b0;
    if (bus.en && same) begin
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
      acc_d = (cnt_q == CNT_PRE);
    end
  end

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    err_d   = err_q;
    load    = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      seen_d  = '0;
      err_d   = 1'b0;
    end else begin
      // Clearing before OR-ing lets an accept during DONE start the next frame
      if (state_q == DONE) begin
        load   = 1'b1;
        seen_d = '0;
      end
      if (capture) seen_d = seen_d | smp_an_q;
      if (accept && !an_zero && (!an_onehot || dec[4])) err_d = 1'b1;
      case (state_q)
        IDLE:    state_d = COLLECT;
        COLLECT: if (&seen_d) state_d = DONE;
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      smp_seg_q     <= '0;
      smp_an_q      <= '0;
      cnt_q         <= '0;
      acc_q         <= 1'b0;
      seen_q        <= '0;
      err_q         <= 1'b0;
      shadow_nib_q  <= '0;
      shadow_vld_q  <= '0;
      value_q       <= '0;
      digit_valid_q <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      smp_seg_q <= bus.segments;
      smp_an_q  <= bus.anode_active;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      seen_q    <= seen_d;
      err_q     <= err_d;
      for (int i = 0; i < DIGITS; i++) begin
        if (capture && smp_an_q[i]) begin
          shadow_nib_q[4*i +: 4] <= dec[3:0];
          shadow_vld_q[i]        <= dec[5];
        end
      end
      if (load) begin
        value_q       <= shadow_nib_q;
        digit_valid_q <= shadow_vld_q;
        frame_valid_q <= &shadow_vld_q;
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_done  = load;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Directed bench for seven_seg_scan_capture: a frame-level reference model checked every
// cycle, plus hand-computed expectations at the end of each scenario.
module tb_seven_seg_scan_capture;

  localparam int DIGITS = 4;
  localparam int S      = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_seg_scan_capture_if #(.DIGITS(DIGITS)) bus();

  seven_seg_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] BAD   = 7'b0101010;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_decode(input bit [6:0] s, output bit [3:0] nib,
                                   output bit vld, output bit bad);
    nib = 4'hE; vld = 1'b0; bad = 1'b1;
    if (s == BLANK) begin nib = 4'hF; bad = 1'b0; end
    for (int d = 0; d < 10; d++)
      if (s == SEG[d]) begin nib = 4'(d); vld = 1'b1; bad = 1'b0; end
  endfunction

  // Reference model: a pattern is taken once it has been sampled S times in a row with
  // capture enabled; a frame is published the cycle after every position has been taken.
  bit [10:0] m_prev_inp, m_prev2;
  bit        m_prev_en, m_acc, m_done, m_rst_prev;
  bit [10:0] m_acc_pat;
  int        m_run;
  bit [3:0]  m_seen, m_shv, m_dv;
  bit [3:0]  m_nib [DIGITS];
  bit [15:0] m_value;
  bit        m_fv, m_err;
  bit [3:0]  t_an, t_nib;
  bit        t_vld, t_bad, t_acc;

  always @(negedge clk) begin
    if (!rst_n || !m_rst_prev) begin
      m_seen = '0; m_shv = '0; m_dv = '0; m_value = '0; m_fv = 1'b0; m_err = 1'b0;
      for (int i = 0; i < DIGITS; i++) m_nib[i] = '0;
      m_prev2    = '0;
      m_prev_inp = {bus.anode_active, bus.segments};
      m_prev_en  = bus.en;
      m_run = 0; m_acc = 1'b0; m_done = 1'b0;
      check("rst_value", 32'(bus.value), 32'h0);
      check("rst_frame_done", 32'(bus.frame_done), 32'h0);
      check("rst_err", 32'(bus.err), 32'h0);
    end else begin
      if (!m_prev_en) begin
        m_seen = '0; m_err = 1'b0; m_done = 1'b0;
      end else begin
        if (m_done) begin
          for (int i = 0; i < DIGITS; i++) m_value[4*i +: 4] = m_nib[i];
          m_dv = m_shv; m_fv = (m_shv == 4'hF); m_seen = '0;
        end
        if (m_acc) begin
          t_an = m_acc_pat[10:7];
          if (t_an != 0) begin
            if ($countones(t_an) != 1) m_err = 1'b1;
            else begin
              m_decode(m_acc_pat[6:0], t_nib, t_vld, t_bad);
              for (int i = 0; i < DIGITS; i++)
                if (t_an[i]) begin m_nib[i] = t_nib; m_shv[i] = t_vld; m_seen[i] = 1'b1; end
              if (t_bad) m_err = 1'b1;
            end
          end
        end
        m_done = !m_done && (m_seen == 4'hF);
      end
      if (m_prev_en && (m_prev_inp == m_prev2)) m_run++; else m_run = 0;
      t_acc = (m_run == S - 1) && bus.en;
      check("value", 32'(bus.value), 32'(m_value));
      check("digit_valid", 32'(bus.digit_valid), 32'(m_dv));
      check("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
      check("frame_done", 32'(bus.frame_done), 32'(m_done && bus.en));
      check("err", 32'(bus.err), 32'(m_err));
      m_acc      = t_acc;
      m_acc_pat  = m_prev_inp;
      m_prev2    = m_prev_inp;
      m_prev_inp = {bus.anode_active, bus.segments};
      m_prev_en  = bus.en;
    end
    m_rst_prev = rst_n;
    if (bus.frame_done) fd_cnt++;
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    bus.anode_active = an;
    bus.segments     = seg;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame(input int d3, input int d2, input int d1, input int d0);
    drive(4'b1000, SEG[d3], 8);
    drive(4'b0100, SEG[d2], 8);
    drive(4'b0010, SEG[d1], 8);
    drive(4'b0001, SEG[d0], 8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.en = 1'b0; bus.anode_active = '0; bus.segments = BLANK;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("lit_reset_value", 32'(bus.value), 32'h0);
    check("lit_reset_dv", 32'(bus.digit_valid), 32'h0);
    check("lit_reset_fv", 32'(bus.frame_valid), 32'h0);
    check("lit_reset_err", 32'(bus.err), 32'h0);
    bus.en = 1'b1;

    // Full scan 4,3,2,1
    frame(4, 3, 2, 1);
    check("lit_t1_fd_cnt", 32'(fd_cnt), 32'd1);
    check("lit_t1_value", 32'(bus.value), 32'h4321);
    check("lit_t1_dv", 32'(bus.digit_valid), 32'hF);
    check("lit_t1_fv", 32'(bus.frame_valid), 32'h1);
    check("lit_t1_err", 32'(bus.err), 32'h0);

    // Patterns held S-1 cycles are ignored; S cycles are enough
    drive(4'b0001, SEG[5], S - 1);
    drive(4'b0010, SEG[6], S - 1);
    drive(4'b0100, SEG[7], 8);
    drive(4'b1000, SEG[8], 8);
    check("lit_t2_short_fd_cnt", 32'(fd_cnt), 32'd1);
    drive(4'b0001, SEG[5], S);
    drive(4'b0010, SEG[6], S);
    drive(4'b0000, BLANK, 3);
    check("lit_t2_fd_cnt", 32'(fd_cnt), 32'd2);
    check("lit_t2_value", 32'(bus.value), 32'h8765);

    // Blank digit at position 2
    drive(4'b1000, SEG[7], 8);
    drive(4'b0100, BLANK, 8);
    drive(4'b0010, SEG[5], 8);
    drive(4'b0001, SEG[0], 8);
    check("lit_t3_value", 32'(bus.value), 32'h7F50);
    check("lit_t3_dv", 32'(bus.digit_valid), 32'b1011);
    check("lit_t3_fv", 32'(bus.frame_valid), 32'h0);
    check("lit_t3_err", 32'(bus.err), 32'h0);

    // Illegal pattern, sticky error, cleared by one cycle of en low
    drive(4'b1000, SEG[1], 8);
    drive(4'b0100, SEG[2], 8);
    drive(4'b0010, SEG[3], 8);
    drive(4'b0001, BAD, 8);
    check("lit_t4_value", 32'(bus.value), 32'h123E);
    check("lit_t4_dv", 32'(bus.digit_valid), 32'b1110);
    check("lit_t4_err", 32'(bus.err), 32'h1);
    frame(9, 8, 7, 6);
    check("lit_t4_good_value", 32'(bus.value), 32'h9876);
    check("lit_t4_err_held", 32'(bus.err), 32'h1);
    bus.en = 1'b0;
    @(posedge clk); #1;
    bus.en = 1'b1;
    check("lit_t4_err_clr", 32'(bus.err), 32'h0);
    check("lit_t4_value_hold", 32'(bus.value), 32'h9876);
    check("lit_t4_fd_cnt", 32'(fd_cnt), 32'd5);

    // Blanked bus is harmless; non-one-hot anode flags an error without capturing
    drive(4'b0000, SEG[3], 8);
    check("lit_t5_blank_err", 32'(bus.err), 32'h0);
    drive(4'b0011, SEG[3], 8);
    check("lit_t5_multi_err", 32'(bus.err), 32'h1);
    drive(4'b1000, SEG[1], 8);
    drive(4'b0100, SEG[2], 8);
    drive(4'b0010, SEG[3], 8);
    check("lit_t5_partial_fd_cnt", 32'(fd_cnt), 32'd5);
    drive(4'b0001, SEG[4], 8);
    check("lit_t5_fd_cnt", 32'(fd_cnt), 32'd6);
    check("lit_t5_value", 32'(bus.value), 32'h1234);

    // Asynchronous reset mid-frame
    drive(4'b1000, SEG[5], 8);
    drive(4'b0100, SEG[6], 8);
    rst_n = 1'b0;
    #1;
    check("lit_t6_value", 32'(bus.value), 32'h0);
    check("lit_t6_dv", 32'(bus.digit_valid), 32'h0);
    check("lit_t6_fv", 32'(bus.frame_valid), 32'h0);
    check("lit_t6_err", 32'(bus.err), 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(4'b0010, SEG[7], 8);
    drive(4'b0001, SEG[8], 8);
    check("lit_t6_partial_fd_cnt", 32'(fd_cnt), 32'd6);
    drive(4'b1000, SEG[1], 8);
    drive(4'b0100, SEG[2], 8);
    check("lit_t6_fd_cnt", 32'(fd_cnt), 32'd7);
    check("lit_t6_value2", 32'(bus.value), 32'h1278);
    check("lit_t6_fv2", 32'(bus.frame_valid), 32'h1);

    drive(4'b0000, BLANK, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
